seq_scheduler: RTL

Run/pause/single-step controller for the 3-bit six-state ring sequence driven from the 12 MHz board clock. Owns the tick prescaler, the direction-mode interlock and the sequence register, and presents the current 3-bit code plus status pulses to the display/LED logic. Direction input `M` is honoured only at tick boundaries, with a one-tick dwell on every reversal.

---
 rtl/seq_scheduler_pkg.sv | 22 ++
 rtl/seq_next_lut.sv | 38 +++
 rtl/seq_scheduler.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/seq_scheduler_pkg.sv
// Shared definitions for the six-state ring sequencer: FSM encodings,
// fixed sequence codes and the default tick period.
package seq_scheduler_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DWELL = 2'd2,
    S_PAUSE = 2'd3
  } state_t;

  // Code shown while idle / after reset.
  localparam logic [2:0] C_RESET = 3'b111;
  // First code on leaving idle, common to both directions.
  localparam logic [2:0] C_ENTRY = 3'b000;
  // Ring start/end point; reaching it from the ring completes a revolution.
  localparam logic [2:0] C_HOME  = 3'b110;

  // 12 MHz board clock -> one advance per second.
  localparam int unsigned CLOCK_DEFAULT = 32'd12_000_000;

endpackage

// File: rtl/seq_next_lut.sv
// Next-code table for the ring sequence. Purely combinational so the display
// test pattern generator can reuse it without pulling in the scheduler.
module seq_next_lut
  import seq_scheduler_pkg::*;
(
  input  logic [2:0] code,
  input  logic       dir,
  output logic [2:0] code_next,
  output logic       wrap
);

  // Forward and reverse rings share the entry path 111 -> 000 -> 110.
  always_comb begin
    code_next = C_ENTRY;
    wrap      = 1'b0;
    case (code)
      C_RESET: code_next = C_ENTRY;
      C_ENTRY: code_next = C_HOME;
      3'b110:  code_next = dir ? 3'b100 : 3'b010;
      3'b100: begin
        code_next = dir ? 3'b101 : C_HOME;
        wrap      = ~dir;
      end
      3'b101:  code_next = dir ? 3'b001 : 3'b100;
      3'b001:  code_next = dir ? 3'b011 : 3'b101;
      3'b011:  code_next = dir ? 3'b010 : 3'b001;
      3'b010: begin
        code_next = dir ? C_HOME : 3'b011;
        wrap      = dir;
      end
      default: begin
        code_next = C_ENTRY;
        wrap      = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seq_scheduler.sv
// Run/pause/single-step scheduler for the six-state ring sequence.
// Holds the tick prescaler, direction interlock, sequence register and the
// registered status outputs consumed by the display/LED logic.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | parked at 111, counters cleared, direction tracks M
// RUN   | free running, one advance per CLOCK cycles
// DWELL | one silent period after a direction reversal, then advance
// PAUSE | frozen; step advances once, start resumes, stop returns to IDLE
module seq_scheduler
  import seq_scheduler_pkg::*;
#(
  parameter int unsigned CLOCK = CLOCK_DEFAULT
) (
  input  logic       clk,
  input  logic       CR,
  input  logic       start,
  input  logic       stop,
  input  logic       step,
  input  logic       M,
  output logic [2:0] data,
  output logic       run,
  output logic       tick,
  output logic       rev,
  output logic [7:0] steps
);

  localparam int TW = $clog2(CLOCK);
  localparam logic [TW-1:0] T_LAST = TW'(CLOCK - 1);

  state_t        state;
  logic [TW-1:0] timer;
  logic          dir;

  logic          adv_dir;
  logic [2:0]    lut_next;
  logic          lut_wrap;
  logic          period_end;

  // Free-running states advance in the latched direction; single steps use M
  // directly since a step is never subject to the reversal dwell.
  always_comb begin
    adv_dir    = M;
    if (state == S_RUN || state == S_DWELL) adv_dir = dir;
    period_end = (timer == T_LAST);
  end

  seq_next_lut u_lut (
    .code      (data),
    .dir       (adv_dir),
    .code_next (lut_next),
    .wrap      (lut_wrap)
  );

  // Sequencer FSM with prescaler, direction interlock and registered outputs.
  // Pulse priority is stop > start > step in every state.
  always_ff @(posedge clk or negedge CR) begin
    if (!CR) begin
      state <= S_IDLE;
      data  <= C_RESET;
      run   <= 1'b0;
      tick  <= 1'b0;
      rev   <= 1'b0;
      steps <= 8'd0;
      timer <= '0;
      dir   <= 1'b1;
    end else begin
      tick <= 1'b0;
      rev  <= 1'b0;
      case (state)
        S_IDLE: begin
          data  <= C_RESET;
          timer <= '0;
          steps <= 8'd0;
          dir   <= M;
          if (!stop) begin
            if (start) begin
              state <= S_RUN;
              run   <= 1'b1;
            end else if (step) begin
              data  <= lut_next;
              steps <= 8'd1;
              tick  <= 1'b1;
              rev   <= lut_wrap;
              state <= S_PAUSE;
            end
          end
        end

        S_RUN: begin
          if (stop) begin
            state <= S_PAUSE;
            run   <= 1'b0;
          end else if (period_end) begin
            timer <= '0;
            if (M == dir) begin
              data  <= lut_next;
              steps <= steps + 8'd1;
              tick  <= 1'b1;
              rev   <= lut_wrap;
            end else begin
              // Reversal: latch the new direction and sit out one period.
              dir   <= M;
              state <= S_DWELL;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

        S_DWELL: begin
          if (stop) begin
            state <= S_PAUSE;
            run   <= 1'b0;
          end else if (period_end) begin
            timer <= '0;
            data  <= lut_next;
            steps <= steps + 8'd1;
            tick  <= 1'b1;
            rev   <= lut_wrap;
            state <= S_RUN;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        S_PAUSE: begin
          if (stop) begin
            state <= S_IDLE;
            data  <= C_RESET;
            steps <= 8'd0;
            timer <= '0;
            dir   <= M;
          end else if (start) begin
            // Any partial period accumulated before the pause is discarded.
            state <= S_RUN;
            timer <= '0;
            run   <= 1'b1;
          end else if (step) begin
            dir   <= M;
            data  <= lut_next;
            steps <= steps + 8'd1;
            tick  <= 1'b1;
            rev   <= lut_wrap;
          end
        end

        default: begin
          state <= S_IDLE;
          run   <= 1'b0;
        end
      endcase
    end
  end

endmodule
